// File: rtl/cyx_mc_controller_if.sv
// Control bundle between the nanoMIPS multi-cycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath/memory model.
interface cyx_mc_controller_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      inst;
   logic             zero;
   logic             mem_ready;
   logic             MemRd;
   logic             MemWr;
   logic             IorD;
   logic             IRWr;
   logic             PCWr;
   logic             RegWr;
   logic [1:0]       RegDst;
   logic [1:0]       MemtoReg;
   logic             ExtOp;
   logic             ALUsrcA;
   logic [1:0]       ALUsrcB;
   logic [3:0]       ALUctr;
   logic [1:0]       PCsrc;
   logic [3:0]       state;
   logic [1:0]       fault;
   logic [CNT_W-1:0] instret;

   // Handshake: MemRd/MemWr stay high until the cycle in which mem_ready is high; that cycle completes the access.
   modport master (
      input  inst, zero, mem_ready,
      output MemRd, MemWr, IorD, IRWr, PCWr, RegWr, RegDst, MemtoReg,
             ExtOp, ALUsrcA, ALUsrcB, ALUctr, PCsrc, state, fault, instret
   );

   modport slave (
      output inst, zero, mem_ready,
      input  MemRd, MemWr, IorD, IRWr, PCWr, RegWr, RegDst, MemtoReg,
             ExtOp, ALUsrcA, ALUsrcB, ALUctr, PCsrc, state, fault, instret
   );
endinterface

// File: rtl/cyx_mc_controller.sv
// Multi-cycle nanoMIPS control FSM: fetch/decode/execute/mem/write-back sequencing,
// illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module cyx_mc_controller #(
   parameter bit EXT_ISA = 1'b1,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cyx_mc_controller_if.master   bus
);
   typedef enum logic [3:0] {
      S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
      S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_REXEC = 4'd7,
      S_RWB = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_BRANCH = 4'd11,
      S_JUMP = 4'd12, S_TRAP = 4'd13
   } state_t;

   localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_JAL = 6'd3, OP_BEQ = 6'd4,
                          OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_SLTI = 6'd10,
                          OP_ANDI = 6'd12, OP_ORI = 6'd13, OP_LW = 6'd35, OP_SW = 6'd43;
   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                          ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
   localparam int             WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0]  LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t           r_state, w_next;
   logic [1:0]       r_fault, w_fault_set;
   logic [CNT_W-1:0] r_instret;
   logic [WW-1:0]    r_wait, w_wait_nxt;
   logic             w_retire, w_timeout, w_in_wait, w_r_alu, w_unused;
   logic             w_memrd, w_memwr, w_iord, w_irwr, w_pcwr, w_regwr, w_extop, w_srca;
   logic [1:0]       w_regdst, w_memtoreg, w_srcb, w_pcsrc;
   logic [3:0]       w_aluctr;
   logic [5:0]       w_op, w_funct;

   assign w_op     = bus.inst[31:26];
   assign w_funct  = bus.inst[5:0];
   assign w_unused = ^bus.inst[25:6];
   assign w_r_alu  = (w_funct == 6'd32) || (w_funct == 6'd34) || (w_funct == 6'd36) ||
                     (w_funct == 6'd37) || (w_funct == 6'd42);
   assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   // Timeout fires only on the TIMEOUT-th idle cycle; a ready on that cycle still wins.
   assign w_timeout = (TIMEOUT != 0) && !bus.mem_ready && (r_wait == LAST);

   always_comb begin
      w_next = r_state;  w_retire = 1'b0;  w_fault_set = 2'b00;
      w_memrd = 1'b0;  w_memwr = 1'b0;  w_iord = 1'b0;  w_irwr = 1'b0;
      w_pcwr = 1'b0;  w_regwr = 1'b0;  w_extop = 1'b0;  w_srca = 1'b0;
      w_regdst = 2'd0;  w_memtoreg = 2'd0;  w_srcb = 2'd0;  w_pcsrc = 2'd0;
      w_aluctr = ALU_AND;
      case (r_state)
         S_INIT: w_next = S_FETCH;
         S_FETCH: begin
            w_memrd = 1'b1;  w_srcb = 2'd1;  w_aluctr = ALU_ADD;
            if (bus.mem_ready) begin
               w_irwr = 1'b1;  w_pcwr = 1'b1;  w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_TRAP;  w_fault_set = 2'b10;
            end
         end
         S_DECODE: begin
            w_srcb = 2'd3;  w_extop = 1'b1;  w_aluctr = ALU_ADD;
            w_next = S_TRAP;
            case (w_op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R: begin
                  if (w_r_alu)                          w_next = S_REXEC;
                  else if (EXT_ISA && w_funct == 6'd8)  w_next = S_JUMP;
               end
               OP_BEQ:                              w_next = S_BRANCH;
               OP_BNE:  if (EXT_ISA)                w_next = S_BRANCH;
               OP_J:                                w_next = S_JUMP;
               OP_JAL:  if (EXT_ISA)                w_next = S_JUMP;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: if (EXT_ISA) w_next = S_IEXEC;
               default: ;
            endcase
            if (w_next == S_TRAP) w_fault_set = 2'b01;
         end
         S_MEMADR: begin
            w_srca = 1'b1;  w_srcb = 2'd2;  w_extop = 1'b1;  w_aluctr = ALU_ADD;
            w_next = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_memrd = 1'b1;  w_iord = 1'b1;
            if (bus.mem_ready)  w_next = S_MEMWB;
            else if (w_timeout) begin w_next = S_TRAP;  w_fault_set = 2'b10; end
         end
         S_MEMWB: begin
            w_regwr = 1'b1;  w_memtoreg = 2'd1;  w_next = S_FETCH;  w_retire = 1'b1;
         end
         S_MEMWR: begin
            w_memwr = 1'b1;  w_iord = 1'b1;
            if (bus.mem_ready)  begin w_next = S_FETCH;  w_retire = 1'b1; end
            else if (w_timeout) begin w_next = S_TRAP;  w_fault_set = 2'b10; end
         end
         S_REXEC: begin
            w_srca = 1'b1;  w_next = S_RWB;
            case (w_funct)
               6'd34:   w_aluctr = ALU_SUB;
               6'd36:   w_aluctr = ALU_AND;
               6'd37:   w_aluctr = ALU_OR;
               6'd42:   w_aluctr = ALU_SLT;
               default: w_aluctr = ALU_ADD;
            endcase
         end
         S_RWB: begin
            w_regwr = 1'b1;  w_regdst = 2'd1;  w_next = S_FETCH;  w_retire = 1'b1;
         end
         S_IEXEC: begin
            w_srca = 1'b1;  w_srcb = 2'd2;  w_next = S_IWB;
            case (w_op)
               OP_ANDI: w_aluctr = ALU_AND;
               OP_ORI:  w_aluctr = ALU_OR;
               OP_SLTI: begin w_aluctr = ALU_SLT;  w_extop = 1'b1; end
               default: begin w_aluctr = ALU_ADD;  w_extop = 1'b1; end
            endcase
         end
         S_IWB: begin
            w_regwr = 1'b1;  w_next = S_FETCH;  w_retire = 1'b1;
         end
         S_BRANCH: begin
            w_srca = 1'b1;  w_aluctr = ALU_SUB;  w_pcsrc = 2'd1;
            w_pcwr = (w_op == OP_BNE) ? ~bus.zero : bus.zero;
            w_next = S_FETCH;  w_retire = 1'b1;
         end
         S_JUMP: begin
            w_pcwr = 1'b1;  w_pcsrc = (w_op == OP_R) ? 2'd3 : 2'd2;
            // jal links the already-incremented PC into r31.
            if (w_op == OP_JAL) begin
               w_regwr = 1'b1;  w_regdst = 2'd2;  w_memtoreg = 2'd2;
            end
            w_next = S_FETCH;  w_retire = 1'b1;
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_INIT;
      endcase
   end

   assign w_wait_nxt = ((TIMEOUT != 0) && w_in_wait && (w_next == r_state)) ?
                       r_wait + WW'(1) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_INIT;
         r_fault   <= 2'b00;
         r_instret <= '0;
         r_wait    <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_nxt;
         if (w_fault_set != 2'b00) r_fault   <= w_fault_set;
         if (w_retire)             r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign bus.MemRd    = w_memrd;
   assign bus.MemWr    = w_memwr;
   assign bus.IorD     = w_iord;
   assign bus.IRWr     = w_irwr;
   assign bus.PCWr     = w_pcwr;
   assign bus.RegWr    = w_regwr;
   assign bus.RegDst   = w_regdst;
   assign bus.MemtoReg = w_memtoreg;
   assign bus.ExtOp    = w_extop;
   assign bus.ALUsrcA  = w_srca;
   assign bus.ALUsrcB  = w_srcb;
   assign bus.ALUctr   = w_aluctr;
   assign bus.PCsrc    = w_pcsrc;
   assign bus.state    = r_state;
   assign bus.fault    = r_fault;
   assign bus.instret  = r_instret;
endmodule

// File: tb/tb_cyx_mc_controller.sv
// Directed bench for cyx_mc_controller: per-cycle control vectors from a scoreboard queue,
// plus a second instance built without the extended ISA.
module tb_cyx_mc_controller;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   cyx_mc_controller_if #(.CNT_W(4))  if1 ();
   cyx_mc_controller_if #(.CNT_W(32)) if2 ();

   cyx_mc_controller #(.EXT_ISA(1'b1), .TIMEOUT(4), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));
   cyx_mc_controller #(.EXT_ISA(1'b0), .TIMEOUT(0), .CNT_W(32)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] exp_q[$];
   logic [1:0]  stim_q[$];

   // Packed view: state, {MemRd,MemWr,IorD,IRWr,PCWr,RegWr}, RegDst, MemtoReg, ExtOp, ALUsrcA, ALUsrcB, ALUctr, PCsrc.
   function automatic logic [23:0] v(input logic [3:0] st, input logic [5:0] stb,
                                     input logic [1:0] rd, input logic [1:0] mr,
                                     input logic ext, input logic sa, input logic [1:0] sb,
                                     input logic [3:0] ctr, input logic [1:0] pcs);
      return {st, stb, rd, mr, ext, sa, sb, ctr, pcs};
   endfunction

   function automatic logic [23:0] obs1();
      return v(if1.state, {if1.MemRd, if1.MemWr, if1.IorD, if1.IRWr, if1.PCWr, if1.RegWr},
               if1.RegDst, if1.MemtoReg, if1.ExtOp, if1.ALUsrcA, if1.ALUsrcB, if1.ALUctr, if1.PCsrc);
   endfunction

   function automatic logic [23:0] obs2();
      return v(if2.state, {if2.MemRd, if2.MemWr, if2.IorD, if2.IRWr, if2.PCWr, if2.RegWr},
               if2.RegDst, if2.MemtoReg, if2.ExtOp, if2.ALUsrcA, if2.ALUsrcB, if2.ALUctr, if2.PCsrc);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic rdy, input logic z, input logic [23:0] e);
      stim_q.push_back({rdy, z});
      exp_q.push_back(e);
   endtask

   // Called at posedge+1: drives the queued inputs, compares at the falling edge.
   task automatic drain(input string tag);
      logic [1:0]  s;
      logic [23:0] e;
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         if1.mem_ready = s[1];
         if1.zero      = s[0];
         @(negedge clk);
         chk(tag, {8'h0, obs1()}, {8'h0, e});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reset_dut(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_async_state"}, {28'h0, if1.state}, 32'h0);
      @(negedge clk);
      chk({tag, "_vec"},     {8'h0, obs1()}, 32'h0);
      chk({tag, "_fault"},   {30'h0, if1.fault}, 32'h0);
      chk({tag, "_instret"}, {28'h0, if1.instret}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [23:0] V_INIT, V_FETCH_R, V_FETCH_W, V_DEC, V_REXEC, V_RWB, V_MEMADR, V_MEMRD;
   logic [23:0] V_MEMWB, V_MEMWR, V_BEQ, V_BNE, V_JAL, V_TRAP;
   logic [3:0]  dut2_st[5];

   initial begin
      V_INIT    = v(4'd0,  6'b000000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
      V_FETCH_R = v(4'd1,  6'b100110, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 4'b0010, 2'd0);
      V_FETCH_W = v(4'd1,  6'b100000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 4'b0010, 2'd0);
      V_DEC     = v(4'd2,  6'b000000, 2'd0, 2'd0, 1'b1, 1'b0, 2'd3, 4'b0010, 2'd0);
      V_REXEC   = v(4'd7,  6'b000000, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 4'b0010, 2'd0);
      V_RWB     = v(4'd8,  6'b000001, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
      V_MEMADR  = v(4'd3,  6'b000000, 2'd0, 2'd0, 1'b1, 1'b1, 2'd2, 4'b0010, 2'd0);
      V_MEMRD   = v(4'd4,  6'b101000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
      V_MEMWB   = v(4'd5,  6'b000001, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
      V_MEMWR   = v(4'd6,  6'b011000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
      V_BEQ     = v(4'd11, 6'b000010, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 4'b0110, 2'd1);
      V_BNE     = v(4'd11, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 4'b0110, 2'd1);
      V_JAL     = v(4'd12, 6'b000011, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd2);
      V_TRAP    = v(4'd13, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
      dut2_st   = '{4'd0, 4'd1, 4'd2, 4'd13, 4'd13};

      rst_n = 1'b0;
      if1.inst = 32'h0;  if1.zero = 1'b0;  if1.mem_ready = 1'b0;
      if2.inst = 32'h0C000010;  if2.zero = 1'b0;  if2.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      reset_dut("reset0");

      // add r3,r1,r2
      if1.inst = 32'h00221820;
      push(1'b0, 1'b0, V_INIT);
      push(1'b1, 1'b0, V_FETCH_R);  push(1'b1, 1'b0, V_DEC);
      push(1'b1, 1'b0, V_REXEC);    push(1'b1, 1'b0, V_RWB);
      drain("add");
      chk("add_instret", {28'h0, if1.instret}, 32'd1);

      // lw r2,4(r1) with ready on the 4th MEMRD cycle (exactly at the timeout limit)
      if1.inst = 32'h8C220004;
      push(1'b1, 1'b0, V_FETCH_R);  push(1'b1, 1'b0, V_DEC);  push(1'b1, 1'b0, V_MEMADR);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, V_MEMRD);
      push(1'b1, 1'b0, V_MEMRD);    push(1'b1, 1'b0, V_MEMWB);
      drain("lw");
      chk("lw_instret", {28'h0, if1.instret}, 32'd2);
      chk("lw_fault",   {30'h0, if1.fault},   32'd0);

      if1.inst = 32'h10220003;
      push(1'b1, 1'b1, V_FETCH_R);  push(1'b1, 1'b1, V_DEC);  push(1'b1, 1'b1, V_BEQ);
      drain("beq");
      if1.inst = 32'h14220003;
      push(1'b1, 1'b1, V_FETCH_R);  push(1'b1, 1'b1, V_DEC);  push(1'b1, 1'b1, V_BNE);
      drain("bne");
      chk("br_instret", {28'h0, if1.instret}, 32'd4);

      if1.inst = 32'h0C000010;
      push(1'b1, 1'b0, V_FETCH_R);  push(1'b1, 1'b0, V_DEC);  push(1'b1, 1'b0, V_JAL);
      drain("jal");
      chk("jal_instret", {28'h0, if1.instret}, 32'd5);

      if1.inst = 32'hAC220004;
      push(1'b1, 1'b0, V_FETCH_R);  push(1'b1, 1'b0, V_DEC);
      push(1'b1, 1'b0, V_MEMADR);   push(1'b1, 1'b0, V_MEMWR);
      drain("sw");
      chk("sw_instret", {28'h0, if1.instret}, 32'd6);

      // 17 adds on a 4-bit counter wrap to 1
      reset_dut("reset1");
      if1.inst = 32'h00221820;
      push(1'b0, 1'b0, V_INIT);
      for (int i = 0; i < 17; i++) begin
         push(1'b1, 1'b0, V_FETCH_R);  push(1'b1, 1'b0, V_DEC);
         push(1'b1, 1'b0, V_REXEC);    push(1'b1, 1'b0, V_RWB);
      end
      drain("wrap");
      chk("wrap_instret", {28'h0, if1.instret}, 32'd1);

      // Fetch timeout after 4 idle cycles; trap absorbs even when ready returns
      for (int i = 0; i < 4; i++) push(1'b0, 1'b0, V_FETCH_W);
      push(1'b0, 1'b0, V_TRAP);  push(1'b1, 1'b0, V_TRAP);  push(1'b1, 1'b1, V_TRAP);
      drain("timeout");
      chk("timeout_fault",   {30'h0, if1.fault},   32'd2);
      chk("timeout_instret", {28'h0, if1.instret}, 32'd1);

      reset_dut("reset2");

      // Instance without extended ISA: jal is illegal
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("noext_state", {28'h0, if2.state}, {28'h0, dut2_st[i]});
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("noext_vec",     {8'h0, obs2()},     {8'h0, V_TRAP});
      chk("noext_fault",   {30'h0, if2.fault}, 32'd1);
      chk("noext_instret", if2.instret,        32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
